// File: rtl/retire_commit_unit.sv
// Retire/commit: architectural RAT update, freed-register FIFO, store-commit token counter.
// Latency: RAT write and FIFO push become visible the cycle after retirement; RAT read is combinational.
// Backpressure: free_valid/free_ready and store_commit_valid/ready handshakes; retire_stall is advisory, and overflows drop and set a sticky error.
module retire_commit_unit #(
  parameter int PHY_WIDTH  = 6,
  parameter int FREE_DEPTH = 8,
  parameter int STORE_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 retire_valid,
  input  logic                 store_valid,
  input  logic [4:0]           rd_arch_commit,
  input  logic [PHY_WIDTH-1:0] rd_phy_old_commit,
  input  logic [PHY_WIDTH-1:0] rd_phy_new_commit,
  output logic                 free_valid,
  output logic [PHY_WIDTH-1:0] free_phy,
  input  logic                 free_ready,
  output logic                 store_commit_valid,
  input  logic                 store_commit_ready,
  input  logic [4:0]           arch_rd_addr,
  output logic [PHY_WIDTH-1:0] arch_rd_phy,
  output logic                 retire_stall,
  output logic [31:0]          retired_count,
  output logic                 overflow_err
);

  localparam int AW = $clog2(FREE_DEPTH);
  localparam int SW = $clog2(STORE_MAX + 1);
  localparam logic [AW:0]   C_FULL    = (AW+1)'(FREE_DEPTH);
  localparam logic [AW:0]   C_FULL_M1 = (AW+1)'(FREE_DEPTH - 1);
  localparam logic [SW-1:0] C_SMAX    = SW'(STORE_MAX);
  localparam logic [SW-1:0] C_SMAX_M1 = SW'(STORE_MAX - 1);

  logic [PHY_WIDTH-1:0] r_rat [32];
  logic [PHY_WIDTH-1:0] r_fifo [FREE_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_cnt;
  logic [SW-1:0]        r_pend;
  logic [31:0]          r_ret_cnt;
  logic                 r_stall, r_err;

  logic          w_rat_wr, w_push, w_pop, w_full, w_push_ok, w_free_ovf;
  logic          w_hs, w_st_ovf;
  logic [AW:0]   w_cnt_nxt;
  logic [SW-1:0] w_pend_nxt;

  assign w_rat_wr   = retire_valid && (rd_arch_commit != 5'd0);
  assign w_push     = w_rat_wr && (rd_phy_old_commit != rd_phy_new_commit);
  assign w_full     = (r_cnt == C_FULL);
  assign w_pop      = free_valid && free_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_push_ok  = w_push && (!w_full || w_pop);
  assign w_free_ovf = w_push && w_full && !w_pop;
  assign w_hs       = store_commit_valid && store_commit_ready;
  assign w_st_ovf   = store_valid && (r_pend == C_SMAX) && !w_hs;

  assign free_valid         = (r_cnt != '0);
  assign free_phy           = r_fifo[r_rd_ptr];
  assign store_commit_valid = (r_pend != '0);
  assign arch_rd_phy        = r_rat[arch_rd_addr];
  assign retire_stall       = r_stall;
  assign retired_count      = r_ret_cnt;
  assign overflow_err       = r_err;

  // Next occupancy of the free FIFO and the pending-store counter.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push_ok && !w_pop)      w_cnt_nxt = r_cnt + 1'b1;
    else if (!w_push_ok && w_pop) w_cnt_nxt = r_cnt - 1'b1;
    w_pend_nxt = r_pend;
    if (store_valid && !w_hs && (r_pend != C_SMAX)) w_pend_nxt = r_pend + 1'b1;
    else if (!store_valid && w_hs)                  w_pend_nxt = r_pend - 1'b1;
  end

  // Architectural RAT: identity mapping on reset, committed mapping on retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_rat[i] <= PHY_WIDTH'(i);
    end else if (w_rat_wr) begin
      r_rat[rd_arch_commit] <= rd_phy_new_commit;
    end
  end

  // Free FIFO storage; contents are meaningless while the count is zero.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= rd_phy_old_commit;
  end

  // FIFO pointers, counters, advisory stall and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_ret_cnt <= '0;
      r_stall   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt  <= w_cnt_nxt;
      r_pend <= w_pend_nxt;
      if (retire_valid || store_valid) r_ret_cnt <= r_ret_cnt + 32'd1;
      // Stall tracks the occupancy being entered, so it rises together with the count.
      r_stall <= (w_cnt_nxt >= C_FULL_M1) || (w_pend_nxt >= C_SMAX_M1);
      if (w_free_ovf || w_st_ovf) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_retire_commit_unit.sv
// Bench for retire_commit_unit: vector table for single-cycle behaviour,
// hand sequences for FIFO fill/drain, store tokens and asynchronous reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_retire_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire_valid, store_valid;
  logic [4:0]  rd_arch_commit, arch_rd_addr;
  logic [5:0]  rd_phy_old_commit, rd_phy_new_commit;
  logic        free_valid, free_ready;
  logic [5:0]  free_phy, arch_rd_phy;
  logic        store_commit_valid, store_commit_ready;
  logic        retire_stall, overflow_err;
  logic [31:0] retired_count;

  int n_chk = 0;
  int n_fail = 0;

  retire_commit_unit #(.PHY_WIDTH(6), .FREE_DEPTH(8), .STORE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .retire_valid(retire_valid), .store_valid(store_valid),
    .rd_arch_commit(rd_arch_commit),
    .rd_phy_old_commit(rd_phy_old_commit), .rd_phy_new_commit(rd_phy_new_commit),
    .free_valid(free_valid), .free_phy(free_phy), .free_ready(free_ready),
    .store_commit_valid(store_commit_valid), .store_commit_ready(store_commit_ready),
    .arch_rd_addr(arch_rd_addr), .arch_rd_phy(arch_rd_phy),
    .retire_stall(retire_stall), .retired_count(retired_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rv, sv;
    logic [4:0] rd;
    logic [5:0] old_p, new_p;
    logic       fr, sr;
    logic [4:0] addr;
    logic       e_fv;
    logic [5:0] e_fphy, e_arch;
    logic       e_scv;
    logic [31:0] e_cnt;
    logic       e_stall, e_err;
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic rv, sv, input logic [4:0] rd, input logic [5:0] op, np,
                              input logic fr, sr, input logic [4:0] addr,
                              input logic fv, input logic [5:0] fphy, arch, input logic scv,
                              input logic [31:0] cnt, input logic stall, err);
    vec_t v;
    v.rv = rv; v.sv = sv; v.rd = rd; v.old_p = op; v.new_p = np;
    v.fr = fr; v.sr = sr; v.addr = addr;
    v.e_fv = fv; v.e_fphy = fphy; v.e_arch = arch; v.e_scv = scv;
    v.e_cnt = cnt; v.e_stall = stall; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    retire_valid = 0; store_valid = 0; rd_arch_commit = 0;
    rd_phy_old_commit = 0; rd_phy_new_commit = 0;
    free_ready = 0; store_commit_ready = 0; arch_rd_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    repeat (2) step();
    rst = 1;
    step();
  endtask

  task automatic retire(input logic [4:0] rd, input logic [5:0] op, input logic [5:0] np);
    retire_valid = 1; rd_arch_commit = rd; rd_phy_old_commit = op; rd_phy_new_commit = np;
    step();
    retire_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs;
    //                rv sv rd  old new fr sr addr  fv fphy arch scv cnt st err
    vecs[0] = mk(0, 0, 0,  0,  0, 0, 0, 5,   0, 0,  5,  0, 0, 0, 0);
    vecs[1] = mk(1, 0, 0, 12, 33, 0, 0, 0,   0, 0,  0,  0, 1, 0, 0);
    vecs[2] = mk(1, 0, 5,  5, 40, 0, 0, 5,   1, 5,  40, 0, 2, 0, 0);
    vecs[3] = mk(1, 1, 6,  6, 41, 1, 0, 6,   1, 6,  41, 1, 3, 0, 0);
    vecs[4] = mk(0, 1, 0,  0,  0, 1, 1, 5,   0, 0,  40, 1, 4, 0, 0);
    vecs[5] = mk(1, 0, 7,  7,  7, 0, 0, 7,   0, 0,  7,  1, 5, 0, 0);
    vecs[6] = mk(0, 0, 0,  0,  0, 0, 1, 6,   0, 0,  41, 0, 5, 0, 0);

    do_reset();

    // Table-driven single-cycle behaviour; expectations are post-edge.
    for (int i = 0; i < 7; i++) begin
      retire_valid = vecs[i].rv; store_valid = vecs[i].sv;
      rd_arch_commit = vecs[i].rd;
      rd_phy_old_commit = vecs[i].old_p; rd_phy_new_commit = vecs[i].new_p;
      free_ready = vecs[i].fr; store_commit_ready = vecs[i].sr;
      arch_rd_addr = vecs[i].addr;
      step();
      chk($sformatf("v%0d free_valid", i), 32'(free_valid), 32'(vecs[i].e_fv));
      if (vecs[i].e_fv) chk($sformatf("v%0d free_phy", i), 32'(free_phy), 32'(vecs[i].e_fphy));
      chk($sformatf("v%0d arch_rd_phy", i), 32'(arch_rd_phy), 32'(vecs[i].e_arch));
      chk($sformatf("v%0d store_commit_valid", i), 32'(store_commit_valid), 32'(vecs[i].e_scv));
      chk($sformatf("v%0d retired_count", i), retired_count, vecs[i].e_cnt);
      chk($sformatf("v%0d retire_stall", i), 32'(retire_stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d overflow_err", i), 32'(overflow_err), 32'(vecs[i].e_err));
    end
    idle_inputs();

    // Fill with free_ready low: stall at 7 entries, 9th dropped, then drain in order.
    do_reset();
    arch_rd_addr = 9;
    for (int i = 1; i <= 9; i++) begin
      retire(5'(i), 6'(i), 6'(32 + i));
      if (i == 6) chk("fill6 retire_stall", 32'(retire_stall), 32'd0);
      if (i == 7) chk("fill7 retire_stall", 32'(retire_stall), 32'd1);
      if (i == 8) chk("fill8 overflow_err", 32'(overflow_err), 32'd0);
    end
    chk("fill9 overflow_err", 32'(overflow_err), 32'd1);
    chk("fill9 arch_rd_phy(9)", 32'(arch_rd_phy), 32'd41);
    chk("fill9 retired_count", retired_count, 32'd9);
    free_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain%0d free_valid", k), 32'(free_valid), 32'd1);
      chk($sformatf("drain%0d free_phy", k), 32'(free_phy), 32'(k));
      step();
    end
    chk("drain empty free_valid", 32'(free_valid), 32'd0);
    chk("drain overflow_err sticky", 32'(overflow_err), 32'd1);
    idle_inputs();

    // Full FIFO with simultaneous push and pop: no error, order preserved.
    do_reset();
    for (int i = 1; i <= 8; i++) retire(5'(i), 6'(10 + i), 6'(40 + i));
    free_ready = 1;
    retire(5'd9, 6'd19, 6'd49);
    chk("fullpp overflow_err", 32'(overflow_err), 32'd0);
    chk("fullpp retire_stall", 32'(retire_stall), 32'd1);
    for (int k = 12; k <= 19; k++) begin
      chk($sformatf("fullpp drain %0d free_valid", k), 32'(free_valid), 32'd1);
      chk($sformatf("fullpp drain %0d free_phy", k), 32'(free_phy), 32'(k));
      step();
    end
    chk("fullpp empty free_valid", 32'(free_valid), 32'd0);
    idle_inputs();

    // Store tokens: three pulses, then exactly three handshakes.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      store_valid = 1; step(); store_valid = 0;
      if (i == 2) chk("st2 retire_stall", 32'(retire_stall), 32'd0);
    end
    chk("st3 retire_stall", 32'(retire_stall), 32'd1);
    chk("st3 store_commit_valid", 32'(store_commit_valid), 32'd1);
    store_commit_ready = 1;
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      if (store_commit_valid) hs++;
      step();
    end
    chk("st handshake count", 32'(hs), 32'd3);
    chk("st drained store_commit_valid", 32'(store_commit_valid), 32'd0);
    chk("st no overflow", 32'(overflow_err), 32'd0);
    store_commit_ready = 0;

    // Store counter saturation at STORE_MAX.
    for (int i = 1; i <= 5; i++) begin
      store_valid = 1; step(); store_valid = 0;
      if (i == 4) chk("sat4 overflow_err", 32'(overflow_err), 32'd0);
    end
    chk("sat5 overflow_err", 32'(overflow_err), 32'd1);
    store_commit_ready = 1;
    hs = 0;
    for (int c = 0; c < 10; c++) begin
      if (store_commit_valid) hs++;
      step();
    end
    chk("sat handshake count", 32'(hs), 32'd4);
    idle_inputs();

    // Asynchronous reset mid-stream with four frees queued.
    do_reset();
    store_valid = 1;
    retire(5'd7, 6'd7, 6'd50);
    store_valid = 0;
    for (int i = 1; i <= 3; i++) retire(5'(i), 6'(i), 6'(20 + i));
    arch_rd_addr = 7;
    #1;
    chk("prerst arch_rd_phy(7)", 32'(arch_rd_phy), 32'd50);
    chk("prerst free_valid", 32'(free_valid), 32'd1);
    #1;
    rst = 0;
    #1;
    chk("rst free_valid", 32'(free_valid), 32'd0);
    chk("rst store_commit_valid", 32'(store_commit_valid), 32'd0);
    chk("rst arch_rd_phy(7)", 32'(arch_rd_phy), 32'd7);
    chk("rst retired_count", retired_count, 32'd0);
    chk("rst retire_stall", 32'(retire_stall), 32'd0);
    chk("rst overflow_err", 32'(overflow_err), 32'd0);
    step();
    rst = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
